// File: rtl/multi_sma_engine.sv
// rtl/multi_sma_engine.sv - multi-window SMA engine over one shared circular sample history
// Optional mean-of-squares channel is built when SECOND_MOMENT_EN is defined.
module multi_sma_engine #(
  parameter int                    DATA_W   = 8,
  parameter int                    NUM_WIN  = 6,
  parameter logic [NUM_WIN*16-1:0] WIN_LENS = {16'd200, 16'd100, 16'd50, 16'd20, 16'd10, 16'd5},
  parameter int                    MAX_LEN  = 200,
  parameter int                    SQ_WIN   = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      flush,
  output logic                      out_valid,
  output logic [NUM_WIN*DATA_W-1:0] sma_out,
  output logic [NUM_WIN-1:0]        warm,
  output logic [DATA_W-1:0]         current_data,
  output logic [15:0]               sample_count,
  output logic [2*DATA_W-1:0]       sqr_mean
);

  localparam int PTR_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int SUM_W  = DATA_W + $clog2(MAX_LEN);
  localparam int SMA_SH = SUM_W + 16;
  localparam int SMA_PW = SUM_W + SMA_SH + 1;

  // ceil-ish reciprocal: floor(2^sh / w) + 1 is exact for every x < 2^(sh-16)
  function automatic logic [63:0] recip(input logic [15:0] w, input int sh);
    logic [63:0] one;
    one = 64'd1 << sh;
    return one / {48'd0, w} + 64'd1;
  endfunction

  // index of the sample w positions behind the write pointer
  function automatic logic [PTR_W-1:0] back_idx(input logic [PTR_W-1:0] p, input logic [15:0] w);
    int idx;
    idx = int'(p) - int'(w);
    if (idx < 0) idx = idx + MAX_LEN;
    return PTR_W'(idx);
  endfunction

  logic [DATA_W-1:0] hist [MAX_LEN];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  wr_ptr_nx;
  logic [15:0]       cnt;
  logic [15:0]       cnt_nx;
  logic [SUM_W-1:0]  sum    [NUM_WIN];
  logic [SUM_W-1:0]  sum_nx [NUM_WIN];
  logic [DATA_W-1:0] old    [NUM_WIN];
  logic [DATA_W-1:0] quot   [NUM_WIN];

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [15:0]       s1_cnt;

  always_comb begin
    wr_ptr_nx = (wr_ptr == PTR_W'(MAX_LEN - 1)) ? '0 : wr_ptr + PTR_W'(1);
    cnt_nx    = (cnt < 16'(MAX_LEN)) ? cnt + 16'd1 : cnt;
    for (int n = 0; n < NUM_WIN; n++) begin
      old[n] = '0;
      if (cnt >= WIN_LENS[n*16 +: 16])
        old[n] = hist[back_idx(wr_ptr, WIN_LENS[n*16 +: 16])];
      sum_nx[n] = sum[n] + SUM_W'(data_in) - SUM_W'(old[n]);
    end
  end

  // Stage 1: history write and running-sum update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_LEN; i++) hist[i] <= '0;
      for (int n = 0; n < NUM_WIN; n++) sum[n] <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_cnt   <= '0;
    end else if (flush) begin
      for (int i = 0; i < MAX_LEN; i++) hist[i] <= '0;
      for (int n = 0; n < NUM_WIN; n++) sum[n] <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        hist[wr_ptr] <= data_in;
        for (int n = 0; n < NUM_WIN; n++) sum[n] <= sum_nx[n];
        wr_ptr  <= wr_ptr_nx;
        cnt     <= cnt_nx;
        s1_data <= data_in;
        s1_cnt  <= cnt_nx;
      end
    end
  end

  for (genvar g = 0; g < NUM_WIN; g++) begin : g_div
    localparam logic [15:0]       WLEN = WIN_LENS[g*16 +: 16];
    localparam logic [63:0]       M64  = recip(WLEN, SMA_SH);
    localparam logic [SMA_PW-1:0] M    = M64[SMA_PW-1:0];
    assign quot[g] = DATA_W'((SMA_PW'(sum[g]) * M) >> SMA_SH);
  end

  // Stage 2: registered means and side-band fields
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      sma_out      <= '0;
      warm         <= '0;
      current_data <= '0;
      sample_count <= '0;
    end else if (flush) begin
      out_valid    <= 1'b0;
      warm         <= '0;
      sample_count <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        for (int n = 0; n < NUM_WIN; n++) begin
          sma_out[n*DATA_W +: DATA_W] <= quot[n];
          warm[n] <= (s1_cnt >= WIN_LENS[n*16 +: 16]);
        end
        current_data <= s1_data;
        sample_count <= s1_cnt;
      end
    end
  end

`ifdef SECOND_MOMENT_EN
  localparam int SQ_W  = 2*DATA_W + $clog2(SQ_WIN);
  localparam int SQ_SH = SQ_W + 16;
  localparam int SQ_PW = SQ_W + SQ_SH + 1;
  localparam logic [63:0]      SQ_M64 = recip(16'(SQ_WIN), SQ_SH);
  localparam logic [SQ_PW-1:0] SQ_M   = SQ_M64[SQ_PW-1:0];

  logic [SQ_W-1:0]   sqsum;
  logic [SQ_W-1:0]   sqsum_nx;
  logic [DATA_W-1:0] sq_old;

  always_comb begin
    sq_old = '0;
    if (cnt >= 16'(SQ_WIN)) sq_old = hist[back_idx(wr_ptr, 16'(SQ_WIN))];
    sqsum_nx = sqsum + SQ_W'(data_in) * SQ_W'(data_in) - SQ_W'(sq_old) * SQ_W'(sq_old);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          sqsum <= '0;
    else if (flush)    sqsum <= '0;
    else if (in_valid) sqsum <= sqsum_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     sqr_mean <= '0;
    else if (!flush && s1_valid)  sqr_mean <= (2*DATA_W)'((SQ_PW'(sqsum) * SQ_M) >> SQ_SH);
  end
`else
  assign sqr_mean = '0;
`endif

endmodule

// File: tb/tb_multi_sma_engine.sv
// tb/tb_multi_sma_engine.sv - self-checking bench for multi_sma_engine
`timescale 1ns/1ps
module tb_multi_sma_engine;
  localparam int NW = 6;
  localparam int ML = 200;
  localparam int WL [NW] = '{5, 10, 20, 50, 100, 200};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  data_in = 8'd0;
  logic        out_valid;
  logic [47:0] sma_out;
  logic [5:0]  warm;
  logic [7:0]  current_data;
  logic [15:0] sample_count;
  logic [15:0] sqr_mean;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic [47:0] sma;
    logic [5:0]  warm;
    logic [7:0]  cur;
    logic [15:0] cnt;
    logic [15:0] sq;
  } res_t;

  res_t pend[$];
  res_t obs[$];
  int   samples[$];
  res_t ce;
  res_t co;

  multi_sma_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .flush(flush),
    .out_valid(out_valid), .sma_out(sma_out), .warm(warm), .current_data(current_data),
    .sample_count(sample_count), .sqr_mean(sqr_mean)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: mean of the last W accepted samples, missing samples count as zero
  task automatic model_push(input int d);
    res_t r;
    int   s;
    int   idx;
    samples.push_back(d);
    r.due = cyc + 2;
    r.cur = d[7:0];
    for (int n = 0; n < NW; n++) begin
      s = 0;
      for (int i = 0; i < WL[n]; i++) begin
        idx = samples.size() - 1 - i;
        if (idx >= 0) s += samples[idx];
      end
      r.sma[n*8 +: 8] = 8'(s / WL[n]);
      r.warm[n] = (samples.size() >= WL[n]);
    end
    r.cnt = 16'((samples.size() > ML) ? ML : samples.size());
    r.sq = 16'd0;
`ifdef SECOND_MOMENT_EN
    s = 0;
    for (int i = 0; i < 20; i++) begin
      idx = samples.size() - 1 - i;
      if (idx >= 0) s += samples[idx] * samples[idx];
    end
    r.sq = 16'(s / 20);
`endif
    pend.push_back(r);
  endtask

  task automatic step(input logic v, input int d, input logic f);
    in_valid = v;
    data_in  = 8'(d);
    flush    = f;
    if (f) begin
      samples.delete();
      for (int i = pend.size() - 1; i >= 0; i--)
        if (pend[i].due > cyc) pend.delete(i);
    end else if (v) begin
      model_push(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ce = pend.pop_front();
      chk("out_valid", out_valid, 1);
      chk("sma_out", sma_out, ce.sma);
      chk("warm", warm, ce.warm);
      chk("current_data", current_data, ce.cur);
      chk("sample_count", sample_count, ce.cnt);
      chk("sqr_mean", sqr_mean, ce.sq);
      co.due = cyc; co.sma = sma_out; co.warm = warm; co.cur = current_data;
      co.cnt = sample_count; co.sq = sqr_mean;
      obs.push_back(co);
    end else if (rst) begin
      chk("out_valid_idle", out_valid, 0);
    end
  end

  initial begin
    #12;
    chk("reset out_valid", out_valid, 0);
    chk("reset sma_out", sma_out, 0);
    chk("reset warm", warm, 0);
    chk("reset sample_count", sample_count, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // constant 100 into a cold engine
    obs.delete();
    for (int i = 0; i < 5; i++) step(1'b1, 100, 1'b0);
    idle(3);
    chk("t1 results", obs.size(), 5);
    for (int i = 0; i < 5; i++) chk("t1 ch5 mean", obs[i].sma[7:0], 20 * (i + 1));
    chk("t1 warm before", obs[3].warm[0], 0);
    chk("t1 warm at 5th", obs[4].warm[0], 1);

    // continuous ramp through pointer wrap
    step(1'b0, 0, 1'b1);
    obs.delete();
    for (int v = 1; v <= 250; v++) step(1'b1, v, 1'b0);
    idle(3);
    chk("t2 results", obs.size(), 250);
    chk("t2 ch200 at 200", obs[199].sma[47:40], 100);
    chk("t2 ch200 at 201", obs[200].sma[47:40], 101);
    chk("t2 ch200 at 250", obs[249].sma[47:40], 150);
    chk("t2 ch100 at 250", obs[249].sma[39:32], 200);
    chk("t2 ch5 at 250", obs[249].sma[7:0], 248);
    chk("t2 count sat", obs[249].cnt, 200);
    for (int n = 0; n < NW; n++) begin
      chk("t2 warm rise", obs[WL[n]-1].warm[n], 1);
      chk("t2 warm pre", obs[WL[n]-2].warm[n], 0);
    end

    // gapped constant full-scale input
    step(1'b0, 0, 1'b1);
    obs.delete();
    for (int i = 0; i < 210; i++) begin
      step(1'b1, 255, 1'b0);
      idle(2);
    end
    idle(3);
    chk("t3 results", obs.size(), 210);
    chk("t3 all 255", obs[209].sma, 48'hFFFF_FFFF_FFFF);
    chk("t3 warm all", obs[209].warm, 6'h3F);

    // flush colliding with a sample
    step(1'b0, 0, 1'b1);
    obs.delete();
    for (int i = 0; i < 29; i++) step(1'b1, 7, 1'b0);
    step(1'b1, 30, 1'b1);
    chk("t4 flush count", sample_count, 0);
    chk("t4 flush warm", warm, 0);
    chk("t4 flush valid", out_valid, 0);
    chk("t4 sma held", sma_out[7:0], 7);
    step(1'b1, 50, 1'b0);
    idle(3);
    chk("t4 results", obs.size(), 29);
    chk("t4 ch5 after flush", obs[28].sma[7:0], 10);
    chk("t4 count after flush", obs[28].cnt, 1);

    // asynchronous reset mid-ramp
    step(1'b0, 0, 1'b1);
    for (int v = 1; v <= 12; v++) step(1'b1, v, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    samples.delete();
    pend.delete();
    #1;
    chk("t5 rst out_valid", out_valid, 0);
    chk("t5 rst sma_out", sma_out, 0);
    chk("t5 rst warm", warm, 0);
    chk("t5 rst current_data", current_data, 0);
    chk("t5 rst sample_count", sample_count, 0);
    chk("t5 rst sqr_mean", sqr_mean, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    obs.delete();
    for (int i = 0; i < 5; i++) step(1'b1, 100, 1'b0);
    idle(3);
    chk("t5 results", obs.size(), 5);
    for (int i = 0; i < 5; i++) chk("t5 ch5 mean", obs[i].sma[7:0], 20 * (i + 1));
    chk("t5 warm at 5th", obs[4].warm[0], 1);

    // second moment
    step(1'b0, 0, 1'b1);
    obs.delete();
    for (int i = 0; i < 20; i++) step(1'b1, 16, 1'b0);
    idle(3);
`ifdef SECOND_MOMENT_EN
    chk("t6 sq first", obs[0].sq, 12);
    chk("t6 sq tenth", obs[9].sq, 128);
    chk("t6 sq 20th", obs[19].sq, 256);
`else
    chk("t6 sq off tenth", obs[9].sq, 0);
    chk("t6 sq off 20th", obs[19].sq, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
